// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: a WIDTH-bit add is split into STAGES
// equal chunks, one chunk rippled per stage, with carry and operands registered between stages.
module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int C = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_rca_adder: need WIDTH>=2, 1<=STAGES<=WIDTH and WIDTH divisible by STAGES");
  end

  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ov_q;

  logic             nxt_v [STAGES];
  logic [WIDTH-1:0] nxt_a [STAGES];
  logic [WIDTH-1:0] nxt_b [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];
  logic             nxt_ov;

  logic             stall;
  logic [WIDTH-1:0] ai;
  logic [WIDTH-1:0] bi;
  logic [WIDTH-1:0] si;
  logic             ci;
  logic             vi;
  logic [C-1:0]     sc;
  logic [C:0]       chain;

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ov_q;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  // Operands travel shifted right so each stage always consumes the low chunk;
  // finished sum chunks enter at the top and shift down into final position.
  always_comb begin
    nxt_ov = 1'b0;
    ai     = '0;
    bi     = '0;
    si     = '0;
    ci     = 1'b0;
    vi     = 1'b0;
    sc     = '0;
    chain  = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        ai = a;
        bi = sub ? ~b : b;
        ci = sub ? 1'b1 : cin;
        si = '0;
        vi = in_valid;
      end else begin
        ai = a_q[k-1];
        bi = b_q[k-1];
        ci = c_q[k-1];
        si = s_q[k-1];
        vi = v_q[k-1];
      end
      chain[0] = ci;
      for (int i = 0; i < C; i++) begin
        sc[i]      = ai[i] ^ bi[i] ^ chain[i];
        chain[i+1] = ((ai[i] ^ bi[i]) & chain[i]) | (ai[i] & bi[i]);
      end
      nxt_v[k] = vi;
      nxt_a[k] = ai >> C;
      nxt_b[k] = bi >> C;
      nxt_s[k] = (si >> C) | (WIDTH'(sc) << (WIDTH - C));
      nxt_c[k] = chain[C];
      if (k == STAGES - 1) begin
        nxt_ov = chain[C-1] ^ chain[C];
      end
    end
  end

  // The whole pipe freezes while the output is held back, so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= nxt_v[k];
        a_q[k] <= nxt_a[k];
        b_q[k] <= nxt_b[k];
        s_q[k] <= nxt_s[k];
        c_q[k] <= nxt_c[k];
      end
      ov_q <= nxt_ov;
    end
  end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed bench for pipelined_rca_adder: the 4-stage instance is the main target,
// 1-stage and 16-stage instances share its inputs for latency checks.
module tb_pipelined_rca_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, cout, overflow;
  logic [15:0] sum;
  logic        in_ready1, out_valid1, cout1, overflow1;
  logic [15:0] sum1;
  logic        in_ready16, out_valid16, cout16, overflow16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_rca_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  pipelined_rca_adder #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .overflow(overflow1)
  );

  pipelined_rca_adder #(.WIDTH(16), .STAGES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .cout(cout16), .overflow(overflow16)
  );

  // Reference result packed as {overflow, cout, sum}, built from wide integer adds.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] be;
    logic        c0;
    logic [16:0] full;
    logic [15:0] low;
    be   = sb ? ~y : y;
    c0   = sb ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, be} + 17'(c0);
    low  = {1'b0, x[14:0]} + {1'b0, be[14:0]} + 16'(c0);
    return {full[16] ^ low[15], full[16], full[15:0]};
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_op(input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sb);
    a        = x;
    b        = y;
    cin      = ci;
    sub      = sb;
    in_valid = 1'b1;
  endtask

  // Counts edges from acceptance until the 4-stage result shows, bounded at 40.
  task automatic wait_result(output int edges);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_carry_out();
    int edges;
    do_reset();
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_result(edges);
    checks++; if (edges !== 4) begin errors++; $display("[TB] FAIL carry_latency got=%0d exp=4", edges); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("[TB] FAIL carry_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("[TB] FAIL carry_cout got=%b exp=1", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL carry_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    int edges;
    do_reset();
    drive_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_result(edges);
    checks++; if (sum !== 16'h8000) begin errors++; $display("[TB] FAIL ovf_add_sum got=%h exp=8000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL ovf_add_cout got=%b exp=0", cout); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_add_overflow got=%b exp=1", overflow); end
    @(negedge clk);
    drive_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_result(edges);
    checks++; if (sum !== 16'hFFFE) begin errors++; $display("[TB] FAIL ovf_sub_sum got=%h exp=FFFE", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL ovf_sub_cout got=%b exp=0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_sub_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_subtract();
    int edges;
    do_reset();
    drive_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    wait_result(edges);
    checks++; if (edges !== 4) begin errors++; $display("[TB] FAIL sub_latency got=%0d exp=4", edges); end
    checks++; if (sum !== 16'h7FFF) begin errors++; $display("[TB] FAIL sub_sum got=%h exp=7FFF", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("[TB] FAIL sub_cout got=%b exp=1", cout); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL sub_overflow got=%b exp=1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'hA5A5, 16'h0F0F, 16'hC350};
    logic [15:0] vb [8] = '{16'h4321, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'h5A5A, 16'hF0F1, 16'h3A98};
    logic        vc [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [17:0] expq[$];
    logic [17:0] e;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int stall_cycles = 0;
    do_reset();
    while (got < 8 && cyc < 60) begin
      cyc++;
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (idx < 8) drive_op(va[idx], vb[idx], vc[idx], vs[idx]);
      else in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("[TB] FAIL b2b_in_ready cycle=%0d got=%b exp=%b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (!in_ready) stall_cycles++;
      if (out_valid && out_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
        checks++;
        if ({overflow, cout, sum} !== e) begin
          errors++;
          $display("[TB] FAIL b2b_result%0d got ov=%b c=%b s=%h exp ov=%b c=%b s=%h",
                   got, overflow, cout, sum, e[17], e[16], e[15:0]);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin, sub));
        idx++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=8", got); end
    checks++; if (stall_cycles !== 3) begin errors++; $display("[TB] FAIL b2b_stall_cycles got=%0d exp=3", stall_cycles); end
  endtask

  task automatic test_reset_flush();
    int bad = 0;
    do_reset();
    drive_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(16'h0003, 16'h0004, 1'b1, 1'b0);
    @(negedge clk);
    drive_op(16'h0009, 16'h0005, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_after_reset got=%b exp=0", out_valid); end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL flush_no_output got=%0d valid cycles exp=0", bad); end
  endtask

  task automatic test_stage_latency();
    int e1 = -1;
    int e16 = -1;
    logic [17:0] r1 = '0;
    logic [17:0] r16 = '0;
    do_reset();
    out_ready = 1'b1;
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid1 && e1 < 0) begin e1 = n; r1 = {overflow1, cout1, sum1}; end
      if (out_valid16 && e16 < 0) begin e16 = n; r16 = {overflow16, cout16, sum16}; end
    end
    checks++; if (e1 !== 1) begin errors++; $display("[TB] FAIL lat1_edges got=%0d exp=1", e1); end
    checks++; if (r1 !== 18'h10000) begin errors++; $display("[TB] FAIL lat1_result got=%h exp=10000", r1); end
    checks++; if (e16 !== 16) begin errors++; $display("[TB] FAIL lat16_edges got=%0d exp=16", e16); end
    checks++; if (r16 !== 18'h10000) begin errors++; $display("[TB] FAIL lat16_result got=%h exp=10000", r16); end
  endtask

  initial begin
    test_reset();
    test_carry_out();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_flush();
    test_stage_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
